// File: rtl/asteroids_pkg.sv
// Shared constants and types for the asteroids collision/scoring slice.
// Score amounts are 3-digit BCD so score_box can add them without conversion.
package asteroids_pkg;

    localparam int T_NUM        = 4;
    localparam int AST_ID_W     = 4;
    localparam int GRACE_FRAMES = 120;

    localparam logic [1:0] AST_SIZE_LARGE    = 2'd0;
    localparam logic [1:0] AST_SIZE_MEDIUM   = 2'd1;
    localparam logic [1:0] AST_SIZE_SMALL    = 2'd2;
    localparam logic [1:0] AST_SIZE_RESERVED = 2'd3;

    localparam logic [11:0] SCORE_LARGE  = 12'h020;
    localparam logic [11:0] SCORE_MEDIUM = 12'h050;
    localparam logic [11:0] SCORE_SMALL  = 12'h100;

    typedef enum logic [1:0] {GRACE, PLAY, OVER} arb_state_t;

    // Smaller asteroids are harder to hit, so they are worth more.
    function automatic logic [11:0] score_for_size(input logic [1:0] size);
        logic [11:0] amount;
        case (size)
            AST_SIZE_LARGE:  amount = SCORE_LARGE;
            AST_SIZE_MEDIUM: amount = SCORE_MEDIUM;
            AST_SIZE_SMALL:  amount = SCORE_SMALL;
            default:         amount = 12'h000;
        endcase
        return amount;
    endfunction

endpackage

// File: rtl/frame_sticky.sv
// W sticky bits that collect set pulses across one frame.
// On frame_start the old contents are dropped and that cycle's set bits start the new frame.
module frame_sticky #(
    parameter int W = 1
) (
    input  logic         clk_25,
    input  logic         resetN,
    input  logic         frame_start,
    input  logic [W-1:0] set_bits,
    output logic [W-1:0] flags
);

    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN)
            flags <= '0;
        else if (frame_start)
            flags <= set_bits;
        else
            flags <= flags | set_bits;
    end

endmodule

// File: rtl/collision_arbiter.sv
// Collects per-pixel sprite overlaps during a frame and resolves them into
// single-cycle game events at frame_start; also owns the post-death grace window.
module collision_arbiter #(
    parameter int T_NUM        = asteroids_pkg::T_NUM,
    parameter int AST_ID_W     = asteroids_pkg::AST_ID_W,
    parameter int GRACE_FRAMES = asteroids_pkg::GRACE_FRAMES
) (
    input  logic                clk_25,
    input  logic                resetN,
    input  logic                frame_start,
    input  logic                game_over,
    input  logic                draw_ship,
    input  logic                draw_ast,
    input  logic [AST_ID_W-1:0] ast_id,
    input  logic [1:0]          ast_size,
    input  logic [T_NUM-1:0]    draw_torp,
    output logic                die,
    output logic [T_NUM-1:0]    torp_hit,
    output logic                ast_hit,
    output logic [AST_ID_W-1:0] ast_hit_id,
    output logic [1:0]          ast_hit_size,
    output logic                score_add,
    output logic [11:0]         score_sum,
    output logic                invuln
);

    import asteroids_pkg::*;

    localparam int CNT_W  = $clog2(GRACE_FRAMES + 1);
    localparam int TIDX_W = (T_NUM > 1) ? $clog2(T_NUM) : 1;
    localparam logic [CNT_W-1:0] GRACE_RELOAD = CNT_W'(GRACE_FRAMES);

    logic                ship_pix;
    logic [T_NUM-1:0]    torp_pix;
    logic [T_NUM:0]      sticky_flags;
    logic                ship_f;
    logic [T_NUM-1:0]    tf;
    logic [TIDX_W-1:0]   first_idx;
    logic                capture;
    logic [TIDX_W-1:0]   cap_idx;
    logic [AST_ID_W-1:0] cap_id;
    logic [1:0]          cap_size;

    arb_state_t       state, state_next;
    logic [CNT_W-1:0] grace_cnt, grace_cnt_next;
    logic             die_next, ast_next, score_next;

    assign ship_pix = draw_ship & draw_ast;
    assign torp_pix = draw_torp & {T_NUM{draw_ast}};

    frame_sticky #(.W(T_NUM + 1)) u_sticky (
        .clk_25      (clk_25),
        .resetN      (resetN),
        .frame_start (frame_start),
        .set_bits    ({ship_pix, torp_pix}),
        .flags       (sticky_flags)
    );

    assign ship_f = sticky_flags[T_NUM];
    assign tf     = sticky_flags[T_NUM-1:0];

    always_comb begin
        first_idx = '0;
        for (int t = T_NUM - 1; t >= 0; t--)
            if (torp_pix[t])
                first_idx = TIDX_W'(t);
    end

    // Only the first torpedo hit of a frame is kept; tf==0 means nothing captured yet.
    assign capture = (frame_start || (tf == '0)) && (|torp_pix);

    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            cap_idx  <= '0;
            cap_id   <= '0;
            cap_size <= '0;
        end else if (capture) begin
            cap_idx  <= first_idx;
            cap_id   <= ast_id;
            cap_size <= ast_size;
        end
    end

    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            state     <= GRACE;
            grace_cnt <= GRACE_RELOAD;
        end else begin
            state     <= state_next;
            grace_cnt <= grace_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        grace_cnt_next = grace_cnt;
        if (frame_start) begin
            unique case (state)
                GRACE: begin
                    if (game_over)
                        state_next = OVER;
                    else if (grace_cnt <= CNT_W'(1)) begin
                        state_next     = PLAY;
                        grace_cnt_next = '0;
                    end else
                        grace_cnt_next = grace_cnt - CNT_W'(1);
                end
                PLAY: begin
                    if (game_over)
                        state_next = OVER;
                    else if (ship_f) begin
                        state_next     = GRACE;
                        grace_cnt_next = GRACE_RELOAD;
                    end
                end
                OVER: begin
                    if (!game_over) begin
                        state_next     = GRACE;
                        grace_cnt_next = GRACE_RELOAD;
                    end
                end
                default: state_next = GRACE;
            endcase
        end
    end

    // game_over wins over a same-frame ship hit: the last life is already gone.
    always_comb begin
        invuln     = (state == GRACE);
        die_next   = frame_start && (state == PLAY) && !game_over && ship_f;
        ast_next   = frame_start && (|tf);
        score_next = ast_next && (cap_size != AST_SIZE_RESERVED)
                     && (state != OVER) && !game_over;
    end

    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            die          <= 1'b0;
            torp_hit     <= '0;
            ast_hit      <= 1'b0;
            ast_hit_id   <= '0;
            ast_hit_size <= '0;
            score_add    <= 1'b0;
            score_sum    <= '0;
        end else begin
            die       <= die_next;
            ast_hit   <= ast_next;
            score_add <= score_next;
            torp_hit  <= ast_next ? (T_NUM'(1) << cap_idx) : '0;
            if (ast_next) begin
                ast_hit_id   <= cap_id;
                ast_hit_size <= cap_size;
            end
            if (score_next)
                score_sum <= score_for_size(cap_size);
        end
    end

endmodule

// File: tb/tb_collision_arbiter.sv
// Bench for collision_arbiter: directed scenarios followed by random frames,
// every cycle compared against a frame-level behavioural model.
module tb_collision_arbiter;

    localparam int GRACE = 120;

    logic        clk_25      = 1'b0;
    logic        resetN      = 1'b0;
    logic        frame_start = 1'b0;
    logic        game_over   = 1'b0;
    logic        draw_ship   = 1'b0;
    logic        draw_ast    = 1'b0;
    logic [3:0]  ast_id      = '0;
    logic [1:0]  ast_size    = '0;
    logic [3:0]  draw_torp   = '0;
    logic        die, ast_hit, score_add, invuln;
    logic [3:0]  torp_hit, ast_hit_id;
    logic [1:0]  ast_hit_size;
    logic [11:0] score_sum;

    collision_arbiter #(.T_NUM(4), .AST_ID_W(4), .GRACE_FRAMES(GRACE)) dut (
        .clk_25       (clk_25),
        .resetN       (resetN),
        .frame_start  (frame_start),
        .game_over    (game_over),
        .draw_ship    (draw_ship),
        .draw_ast     (draw_ast),
        .ast_id       (ast_id),
        .ast_size     (ast_size),
        .draw_torp    (draw_torp),
        .die          (die),
        .torp_hit     (torp_hit),
        .ast_hit      (ast_hit),
        .ast_hit_id   (ast_hit_id),
        .ast_hit_size (ast_hit_size),
        .score_add    (score_add),
        .score_sum    (score_sum),
        .invuln       (invuln)
    );

    always #20 clk_25 = ~clk_25;

    int checks = 0;
    int errors = 0;

    // Frame-level model: game mode as (over, frames of grace left), plus what this frame has seen.
    bit          m_over;
    int          m_grace;
    bit          m_ship_seen;
    int          m_first_t;
    logic [3:0]  m_first_id;
    logic [1:0]  m_first_size;
    logic        exp_die, exp_ast_hit, exp_score_add;
    logic [3:0]  exp_torp_hit, exp_id;
    logic [1:0]  exp_size;
    logic [11:0] exp_sum;

    function automatic int points(input logic [1:0] size);
        return (size == 2'd0) ? 20 : (size == 2'd1) ? 50 : 100;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_over = 0; m_grace = GRACE; m_ship_seen = 0; m_first_t = -1;
        m_first_id = '0; m_first_size = '0;
        exp_die = 0; exp_ast_hit = 0; exp_score_add = 0; exp_torp_hit = '0;
        exp_id = '0; exp_size = '0; exp_sum = '0;
    endtask

    task automatic model_step(input logic fs, input logic ship, input logic ast,
                              input logic [3:0] id, input logic [1:0] size, input logic [3:0] torp);
        exp_die = 0; exp_ast_hit = 0; exp_score_add = 0; exp_torp_hit = '0;
        if (fs) begin
            if (m_first_t >= 0) begin
                exp_ast_hit  = 1;
                exp_torp_hit = 4'b0001 << m_first_t;
                exp_id       = m_first_id;
                exp_size     = m_first_size;
                if (m_first_size != 2'd3 && !m_over && !game_over) begin
                    exp_score_add = 1;
                    exp_sum       = to_bcd(points(m_first_size));
                end
            end
            if (m_over) begin
                if (!game_over) begin m_over = 0; m_grace = GRACE; end
            end else if (game_over)
                m_over = 1;
            else if (m_grace > 0)
                m_grace--;
            else if (m_ship_seen) begin
                exp_die = 1; m_grace = GRACE;
            end
            m_ship_seen = 0; m_first_t = -1;
        end
        if (ship && ast) m_ship_seen = 1;
        if (ast && m_first_t < 0)
            for (int t = 0; t < 4; t++)
                if (torp[t] && m_first_t < 0) begin
                    m_first_t = t; m_first_id = id; m_first_size = size;
                end
    endtask

    task automatic check1(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        check1("die",          12'(die),          12'(exp_die));
        check1("torp_hit",     12'(torp_hit),     12'(exp_torp_hit));
        check1("ast_hit",      12'(ast_hit),      12'(exp_ast_hit));
        check1("ast_hit_id",   12'(ast_hit_id),   12'(exp_id));
        check1("ast_hit_size", 12'(ast_hit_size), 12'(exp_size));
        check1("score_add",    12'(score_add),    12'(exp_score_add));
        check1("score_sum",    score_sum,         exp_sum);
        check1("invuln",       12'(invuln),       12'(!m_over && m_grace > 0));
    endtask

    // Called at a negedge: drive one pixel cycle, clock it, and check at the next negedge.
    task automatic applyStimulus(input logic fs, input logic ship, input logic ast,
                                 input logic [3:0] id, input logic [1:0] size, input logic [3:0] torp);
        frame_start = fs; draw_ship = ship; draw_ast = ast;
        ast_id = id; ast_size = size; draw_torp = torp;
        model_step(fs, ship, ast, id, size, torp);
        @(posedge clk_25);
        @(negedge clk_25);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 4'd0, 2'd0, 4'd0);
    endtask

    task automatic fs_pulse();
        applyStimulus(1, 0, 0, 4'd0, 2'd0, 4'd0);
    endtask

    task automatic run_to_play();
        for (int f = 0; f < GRACE; f++) begin idle(2); fs_pulse(); end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk_25);
        checkOutput();
        resetN = 1'b1;

        $display("[TB] grace: ship collisions ignored for %0d frames", GRACE);
        for (int f = 1; f <= GRACE; f++) begin
            idle(2);
            applyStimulus(0, 1, 1, 4'd1, 2'd0, 4'd0);
            idle(2);
            fs_pulse();
            check1("grace_no_die", 12'(die), 12'd0);
            check1("grace_invuln", 12'(invuln), 12'(f < GRACE));
        end

        $display("[TB] play: ship collision kills");
        idle(2);
        applyStimulus(0, 1, 1, 4'd2, 2'd0, 4'd0);
        idle(2);
        fs_pulse();
        check1("die_pulse", 12'(die), 12'd1);
        check1("die_invuln", 12'(invuln), 12'd1);
        idle(1);

        $display("[TB] two torpedos on one pixel");
        applyStimulus(0, 0, 1, 4'd5, 2'd1, 4'b0110);
        idle(2);
        fs_pulse();
        check1("tie_torp", 12'(torp_hit), 12'h002);
        check1("tie_id", 12'(ast_hit_id), 12'h005);
        check1("tie_sum", score_sum, 12'h050);

        $display("[TB] only first hit per frame");
        applyStimulus(0, 0, 1, 4'd3, 2'd0, 4'b0001);
        idle(2);
        applyStimulus(0, 0, 1, 4'd7, 2'd2, 4'b0100);
        fs_pulse();
        check1("first_torp", 12'(torp_hit), 12'h001);
        check1("first_id", 12'(ast_hit_id), 12'h003);
        check1("first_sum", score_sum, 12'h020);
        applyStimulus(0, 0, 1, 4'd9, 2'd3, 4'b1000);
        fs_pulse();
        check1("rsvd_no_score", 12'(score_add), 12'd0);
        check1("rsvd_ast_hit", 12'(ast_hit), 12'd1);

        $display("[TB] collision on the frame_start cycle");
        run_to_play();
        idle(2);
        applyStimulus(1, 1, 1, 4'd4, 2'd2, 4'b0010);
        check1("coinc_no_die", 12'(die), 12'd0);
        check1("coinc_no_hit", 12'(ast_hit), 12'd0);
        idle(3);
        fs_pulse();
        check1("coinc_die", 12'(die), 12'd1);
        check1("coinc_torp", 12'(torp_hit), 12'h002);
        check1("coinc_sum", score_sum, 12'h100);

        $display("[TB] game over suppresses die and score");
        run_to_play();
        game_over = 1'b1;
        applyStimulus(0, 1, 1, 4'd11, 2'd0, 4'b1000);
        idle(2);
        fs_pulse();
        check1("over_no_die", 12'(die), 12'd0);
        check1("over_no_score", 12'(score_add), 12'd0);
        check1("over_torp", 12'(torp_hit), 12'h008);
        applyStimulus(0, 1, 1, 4'd12, 2'd1, 4'b0001);
        fs_pulse();
        check1("over2_hit", 12'(ast_hit), 12'd1);
        check1("over2_no_score", 12'(score_add), 12'd0);
        game_over = 1'b0;
        idle(2);
        fs_pulse();
        check1("over_exit_invuln", 12'(invuln), 12'd1);

        $display("[TB] async reset mid-frame");
        applyStimulus(0, 1, 1, 4'd6, 2'd0, 4'b0001);
        #5 resetN = 1'b0;
        #5 model_reset();
        checkOutput();
        @(negedge clk_25);
        resetN = 1'b1;
        idle(1);
        fs_pulse();
        check1("rst_no_hit", 12'(ast_hit), 12'd0);

        $display("[TB] random frames");
        for (int f = 0; f < 320; f++) begin
            int len;
            len = $urandom_range(3, 10);
            for (int c = 0; c < len; c++)
                applyStimulus(0, ($urandom % 3) == 0, ($urandom % 3) == 0, 4'($urandom),
                              2'($urandom), (($urandom % 4) == 0) ? 4'($urandom) : 4'd0);
            if (($urandom % 50) == 0) game_over = ~game_over;
            applyStimulus(1, ($urandom % 4) == 0, ($urandom % 3) == 0, 4'($urandom),
                          2'($urandom), (($urandom % 4) == 0) ? 4'($urandom) : 4'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
